// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: baud codes, divisor function, FSM state encoding
// Contents:
//   BAUD_*        3-bit runtime baud select codes, common to uart_rx and uart_tx
//   BAUD_DEFAULT  code used for the divisor register out of reset
//   bps_div()     clocks-per-bit divisor for a given clock frequency and baud code
//   S_* / tx_state_t  transmitter FSM encoding

package uart_pkg;

    localparam logic [2:0] BAUD_9600    = 3'd0;
    localparam logic [2:0] BAUD_19200   = 3'd1;
    localparam logic [2:0] BAUD_38400   = 3'd2;
    localparam logic [2:0] BAUD_57600   = 3'd3;
    localparam logic [2:0] BAUD_115200  = 3'd4;
    localparam logic [2:0] BAUD_DEFAULT = BAUD_9600;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_DATA  = S_DATA,
        ST_STOP  = S_STOP
    } tx_state_t;

    // Divisor is truncated, not rounded, so rx and tx agree bit-for-bit on
    // the same clock. Codes 5..7 are reserved and fall back to 9600.
    function automatic logic [15:0] bps_div(input int unsigned clk_freq,
                                            input logic [2:0]  code);
        int unsigned baud;
        logic [31:0] quot;
        case (code)
            BAUD_9600:   baud = 9600;
            BAUD_19200:  baud = 19200;
            BAUD_38400:  baud = 38400;
            BAUD_57600:  baud = 57600;
            BAUD_115200: baud = 115200;
            default:     baud = 9600;
        endcase
        quot = clk_freq / baud;
        return quot[15:0];
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period divider producing one tick per bit time
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable; counter is held at 0 while low
//   bps[15:0] in   clocks per bit
//   div_cnt   out  position within the current bit, 0..bps-1
//   bit_tick  out  high in the last clock of each bit (div_cnt == bps-1)

module uart_baud_gen
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bps,
    output logic [15:0] div_cnt,
    output logic        bit_tick
);

    assign bit_tick = en && (div_cnt == (bps - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 16'd0;
        end else if (!en || bit_tick) begin
            // Wrapping on the tick lets back-to-back frames keep counting
            // without a restart cycle.
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a one-entry holding buffer
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   STOP_BITS  number of stop bits, 1 or 2
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   baud_set  in   baud code, sampled when a frame starts
//   tx_data   in   byte to send, captured when tx_start && tx_ready
//   tx_start  in   send request strobe
//   tx_ready  out  holding buffer empty
//   tx        out  registered serial line, idle high
//   tx_busy   out  frame on the line (start bit through last stop bit)
//   tx_done   out  pulse in the final clock of the last stop bit

module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_set,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [15:0] BPS_RESET = bps_div(CLK_FREQ, BAUD_DEFAULT);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t   state;
    tx_state_t   state_next;

    logic        buf_valid;
    logic [7:0]  buf_data;
    logic [7:0]  shifter;
    logic [2:0]  bit_cnt;
    logic        stop_cnt;
    logic [15:0] bps_q;
    logic [15:0] div_cnt;
    logic        bit_tick;
    logic        tx_q;
    logic        tx_next;

    logic        accept;
    logic        load_frame;
    logic        shift_bit;
    logic        stop_adv;
    logic        frame_end;
    logic        last_stop;

    // div_cnt is exported by the divider for observability; the FSM only
    // needs the tick.
    logic        unused_div_cnt;
    assign unused_div_cnt = ^div_cnt;

    assign accept    = tx_start && !buf_valid;
    assign last_stop = (stop_cnt == LAST_STOP);

    uart_baud_gen u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state != ST_IDLE),
        .bps      (bps_q),
        .div_cnt  (div_cnt),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_next    = tx_q;
        load_frame = 1'b0;
        shift_bit  = 1'b0;
        stop_adv   = 1'b0;
        frame_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (buf_valid) begin
                    state_next = ST_START;
                    load_frame = 1'b1;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_next = ST_DATA;
                    tx_next    = shifter[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        // shifter[1] becomes the LSB after this edge's shift
                        shift_bit = 1'b1;
                        tx_next   = shifter[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        frame_end = 1'b1;
                        // A queued byte starts its start bit on the very next
                        // clock so consecutive frames leave no idle gap.
                        if (buf_valid) begin
                            state_next = ST_START;
                            load_frame = 1'b1;
                            tx_next    = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        stop_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= 1'b1;
            buf_valid <= 1'b0;
            buf_data  <= 8'd0;
            shifter   <= 8'd0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            bps_q     <= BPS_RESET;
        end else begin
            tx_q <= tx_next;

            // Transfer is ordered before accept so a same-edge refill wins
            // and no byte is lost.
            if (load_frame) begin
                buf_valid <= 1'b0;
            end
            if (accept) begin
                buf_valid <= 1'b1;
                buf_data  <= tx_data;
            end

            if (load_frame) begin
                shifter <= buf_data;
                bps_q   <= bps_div(CLK_FREQ, baud_set);
            end else if (shift_bit) begin
                shifter <= {1'b0, shifter[7:1]};
            end

            // Wraps 7 -> 0 on the final data bit, ready for the next frame.
            if (state == ST_DATA && bit_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (frame_end) begin
                stop_cnt <= 1'b0;
            end else if (stop_adv) begin
                stop_cnt <= 1'b1;
            end
        end
    end

    assign tx       = tx_q;
    assign tx_ready = !buf_valid;
    assign tx_busy  = (state != ST_IDLE);
    assign tx_done  = frame_end;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a line-decoding scoreboard

module tb_uart_tx;

    localparam int CLK_FREQ  = 10_000_000;
    localparam int STOP_BITS = 1;
    localparam int BPS_FAST  = CLK_FREQ / 115200;
    localparam int BPS_SLOW  = CLK_FREQ / 9600;

    typedef struct {
        logic [7:0] data;
        int         bps;
        bit         b2b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] baud_set;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    exp_t sb_q[$];
    int   n_assert   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   mon_frames = 0;
    int   mon_aborts = 0;
    int   done_cnt   = 0;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_set (baud_set),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && tx_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (mon_frames < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("frames_reach_%0d", target), mon_frames, target);
    endtask

    // Line monitor: decodes each frame off tx, checking every sample of every
    // bit against the expected byte and bit period popped from the scoreboard.
    initial begin : monitor
        exp_t e;
        bit   ok;
        bit   aborted;
        int   last_end;
        int   k;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                check("frame_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() == 0) begin
                    k = 0;
                    while (tx !== 1'b1 && k < 20000) begin
                        @(negedge clk);
                        k++;
                    end
                end else begin
                    e = sb_q.pop_front();
                    if (e.b2b) check("back_to_back_gap", cyc - last_end, 1);
                    aborted = 1'b0;
                    ok = (tx_busy === 1'b1);
                    for (int i = 1; i < e.bps && !aborted; i++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                        else if (tx !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
                    end
                    if (!aborted) check($sformatf("start_bit_%02h", e.data), ok, 1'b1);
                    for (int b = 0; b < 8 && !aborted; b++) begin
                        ok = 1'b1;
                        for (int i = 0; i < e.bps && !aborted; i++) begin
                            @(negedge clk);
                            if (rst_n !== 1'b1) aborted = 1'b1;
                            else if (tx !== e.data[b] || tx_busy !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
                        end
                        if (!aborted) check($sformatf("data_%02h_bit%0d", e.data, b), ok, 1'b1);
                    end
                    ok = 1'b1;
                    for (int i = 0; i < STOP_BITS * e.bps && !aborted; i++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                        else if (tx !== 1'b1 || tx_busy !== 1'b1 ||
                                 tx_done !== (i == STOP_BITS * e.bps - 1)) ok = 1'b0;
                    end
                    if (aborted) begin
                        mon_aborts++;
                    end else begin
                        check($sformatf("stop_done_%02h", e.data), ok, 1'b1);
                        last_end = cyc;
                        mon_frames++;
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b1;
        baud_set = 3'd4;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        check("reset_ready", tx_ready, 1'b1);

        check("div_115200_100m", uart_pkg::bps_div(100_000_000, 3'd4), 16'd868);
        check("div_9600_100m", uart_pkg::bps_div(100_000_000, 3'd0), 16'd10416);
        check("div_code7_100m", uart_pkg::bps_div(100_000_000, 3'd7), 16'd10416);
        check("div_57600_100m", uart_pkg::bps_div(100_000_000, 3'd3), 16'd1736);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0x55 at 115200, with accept-to-start latency checks
        sb_q.push_back('{8'h55, BPS_FAST, 1'b0});
        send(8'h55);
        check("accept_ready_low", tx_ready, 1'b0);
        check("accept_tx_idle", tx, 1'b1);
        check("accept_busy_low", tx_busy, 1'b0);
        @(negedge clk);
        check("start_tx_low", tx, 1'b0);
        check("start_ready_high", tx_ready, 1'b1);
        check("start_busy_high", tx_busy, 1'b1);
        wait_frames(1, 3000);
        @(negedge clk);
        check("idle_busy_low", tx_busy, 1'b0);
        check("idle_tx_high", tx, 1'b1);
        check("done_after_55", done_cnt, 1);

        // 0xA5 then 0x3C queued behind it; 0xFF offered while full is dropped
        repeat (10) @(negedge clk);
        sb_q.push_back('{8'hA5, BPS_FAST, 1'b0});
        send(8'hA5);
        repeat (100) @(negedge clk);
        check("ready_before_3c", tx_ready, 1'b1);
        sb_q.push_back('{8'h3C, BPS_FAST, 1'b1});
        send(8'h3C);
        check("ready_after_3c", tx_ready, 1'b0);
        repeat (50) @(negedge clk);
        send(8'hFF);
        check("ready_after_ff", tx_ready, 1'b0);
        wait_frames(3, 5000);
        repeat (2 * BPS_FAST) @(negedge clk);
        check("no_extra_frame", mon_frames, 3);
        check("done_after_3c", done_cnt, 3);
        check("queue_empty_3c", sb_q.size(), 0);

        // baud change in data bit 3 only affects the following frame
        sb_q.push_back('{8'h96, BPS_FAST, 1'b0});
        send(8'h96);
        repeat (1 + 4 * BPS_FAST + 40) @(negedge clk);
        baud_set = 3'd0;
        sb_q.push_back('{8'h69, BPS_SLOW, 1'b1});
        send(8'h69);
        wait_frames(5, 20000);

        // reserved code 7 falls back to 9600
        repeat (10) @(negedge clk);
        baud_set = 3'd7;
        sb_q.push_back('{8'h01, BPS_SLOW, 1'b0});
        send(8'h01);
        wait_frames(6, 15000);

        // reset during data bit 5, then a clean frame
        repeat (10) @(negedge clk);
        baud_set = 3'd4;
        sb_q.push_back('{8'h5A, BPS_FAST, 1'b0});
        send(8'h5A);
        repeat (1 + 6 * BPS_FAST + 40) @(negedge clk);
        check("pre_reset_busy", tx_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_ready", tx_ready, 1'b1);
        check("midrst_done", tx_done, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_seen", mon_aborts, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle_tx", tx, 1'b1);
        sb_q.push_back('{8'h80, BPS_FAST, 1'b0});
        send(8'h80);
        wait_frames(7, 3000);

        repeat (2 * BPS_FAST) @(negedge clk);
        check("final_frames", mon_frames, 7);
        check("final_done_pulses", done_cnt, 7);
        check("final_queue_empty", sb_q.size(), 0);
        check("final_busy", tx_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
